// File: rtl/ifm_pkg.sv
// Shared sizing constants, FSM state type and width helper for the IFM chunk writer.
package ifm_pkg;

  localparam int BUS_SIZE       = 32;
  localparam int CHUNK_SIZE     = 128;
  localparam int SRAM_IFM_NUM   = 4;
  localparam int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } ifm_state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifm_ring_ctrl.sv
// Ring-buffer bookkeeping for IFM chunk slots: write/read slot pointers and
// the count of filled chunks waiting for the reader.
module ifm_ring_ctrl
  import ifm_pkg::*;
#(
  parameter int  SRAM_IFM_NUM = ifm_pkg::SRAM_IFM_NUM,
  localparam int SCW          = cnt_w(SRAM_IFM_NUM),
  localparam int FCW          = $clog2(SRAM_IFM_NUM + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           wr_adv_i,      // last beat of a chunk accepted this cycle
  input  logic           chunk_done_i,  // registered chunk-complete pulse
  input  logic           release_i,     // reader frees the oldest filled chunk
  output logic [SCW-1:0] wr_ptr_o,
  output logic [SCW-1:0] rd_ptr_o,
  output logic [FCW-1:0] fill_o,
  output logic           avail_o,
  output logic           room_o         // a new chunk may still be started
);

  logic [SCW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SCW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] fill_q, fill_d;
  logic           rel_eff;

  // Next pointer and occupancy values; pointers wrap naturally (slot count is a power of two).
  always_comb begin
    rel_eff  = release_i && (fill_q != '0);
    wr_ptr_d = wr_adv_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rel_eff ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    case ({chunk_done_i, rel_eff})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every filled chunk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // A chunk completing this cycle already claims its slot, so it counts against room.
  always_comb begin
    room_o   = (int'(fill_q) + int'(chunk_done_i)) < SRAM_IFM_NUM;
    avail_o  = (fill_q != '0);
    wr_ptr_o = wr_ptr_q;
    rd_ptr_o = rd_ptr_q;
    fill_o   = fill_q;
  end

endmodule

// File: rtl/ifm_chunk_writer.sv
// Accepts sparsemap/nonzero-data beats, sequences them into fixed-size chunks
// and registers one IFM memory write per accepted beat into a ring of chunk slots.
module ifm_chunk_writer
  import ifm_pkg::*;
#(
  parameter int  BUS_SIZE       = ifm_pkg::BUS_SIZE,
  parameter int  CHUNK_SIZE     = ifm_pkg::CHUNK_SIZE,
  parameter int  SRAM_IFM_NUM   = ifm_pkg::SRAM_IFM_NUM,
  localparam int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
  localparam int DCW            = cnt_w(WR_DAT_CYC_NUM),
  localparam int SCW            = cnt_w(SRAM_IFM_NUM),
  localparam int FCW            = $clog2(SRAM_IFM_NUM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BUS_SIZE-1:0]   src_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] src_nonzero_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic                  abort_i,
  input  logic                  chunk_release_i,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [DCW-1:0]        wr_dat_count_o,
  output logic [SCW-1:0]        wr_chunk_count_o,
  output logic                  chunk_done_o,
  output logic                  chunk_avail_o,
  output logic [SCW-1:0]        rd_chunk_count_o,
  output logic [FCW-1:0]        fill_count_o
);

  localparam logic [DCW-1:0] LAST_BEAT = DCW'(WR_DAT_CYC_NUM - 1);

  ifm_state_e            state_q, state_d;
  logic [DCW-1:0]        beat_q, beat_d;
  logic [BUS_SIZE-1:0]   wr_sm_q;
  logic [BUS_SIZE*8-1:0] wr_nz_q;
  logic                  wr_valid_q;
  logic [DCW-1:0]        wr_dat_q;
  logic [SCW-1:0]        wr_chunk_q;
  logic                  done_q;

  logic                  ready;
  logic                  accept;
  logic                  last_beat;
  logic                  rel_eff;
  logic                  room;
  logic                  avail;
  logic [SCW-1:0]        wr_ptr;

  ifm_ring_ctrl #(
    .SRAM_IFM_NUM (SRAM_IFM_NUM)
  ) u_ring (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_adv_i     (accept && last_beat),
    .chunk_done_i (done_q),
    .release_i    (chunk_release_i),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_chunk_count_o),
    .fill_o       (fill_count_o),
    .avail_o      (avail),
    .room_o       (room)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: track chunk progress and the no-free-slot condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!room)                      state_d = ST_FULL;
        else if (accept && !last_beat)  state_d = ST_FILL;
      end
      ST_FILL: begin
        if (abort_i || (accept && last_beat)) state_d = ST_IDLE;
      end
      ST_FULL: begin
        if (rel_eff || room)            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and beat sequencing; abort only rewinds the beat index.
  always_comb begin
    last_beat = (beat_q == LAST_BEAT);
    rel_eff   = chunk_release_i && avail;
    ready     = rst_ni && room && !abort_i;
    accept    = src_valid_i && ready;
    beat_d    = beat_q;
    if (abort_i)     beat_d = '0;
    else if (accept) beat_d = last_beat ? '0 : beat_q + 1'b1;
  end

  // Beat index and the one-cycle-latency write register toward IFM memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      wr_sm_q    <= '0;
      wr_nz_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_dat_q   <= '0;
      wr_chunk_q <= '0;
      done_q     <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      wr_valid_q <= accept;
      done_q     <= accept && last_beat;
      if (accept) begin
        wr_sm_q    <= src_sparsemap_i;
        wr_nz_q    <= src_nonzero_data_i;
        wr_dat_q   <= beat_q;
        wr_chunk_q <= wr_ptr;
      end
    end
  end

  // Drive ports from registered state.
  always_comb begin
    src_ready_o       = ready;
    wr_sparsemap_o    = wr_sm_q;
    wr_nonzero_data_o = wr_nz_q;
    wr_valid_o        = wr_valid_q;
    wr_dat_count_o    = wr_dat_q;
    wr_chunk_count_o  = wr_chunk_q;
    chunk_done_o      = done_q;
    chunk_avail_o     = avail;
  end

endmodule

// File: tb/tb_ifm_chunk_writer.sv
// Directed and randomized bench for ifm_chunk_writer with a slot-queue reference model.
module tb_ifm_chunk_writer;

  localparam int BEATS = 4;
  localparam int SLOTS = 4;

  logic         clk_i;
  logic         rst_ni;
  logic [31:0]  src_sparsemap_i;
  logic [255:0] src_nonzero_data_i;
  logic         src_valid_i;
  logic         src_ready_o;
  logic         abort_i;
  logic         chunk_release_i;
  logic [31:0]  wr_sparsemap_o;
  logic [255:0] wr_nonzero_data_o;
  logic         wr_valid_o;
  logic [1:0]   wr_dat_count_o;
  logic [1:0]   wr_chunk_count_o;
  logic         chunk_done_o;
  logic         chunk_avail_o;
  logic [1:0]   rd_chunk_count_o;
  logic [2:0]   fill_count_o;

  ifm_chunk_writer dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .src_sparsemap_i    (src_sparsemap_i),
    .src_nonzero_data_i (src_nonzero_data_i),
    .src_valid_i        (src_valid_i),
    .src_ready_o        (src_ready_o),
    .abort_i            (abort_i),
    .chunk_release_i    (chunk_release_i),
    .wr_sparsemap_o     (wr_sparsemap_o),
    .wr_nonzero_data_o  (wr_nonzero_data_o),
    .wr_valid_o         (wr_valid_o),
    .wr_dat_count_o     (wr_dat_count_o),
    .wr_chunk_count_o   (wr_chunk_count_o),
    .chunk_done_o       (chunk_done_o),
    .chunk_avail_o      (chunk_avail_o),
    .rd_chunk_count_o   (rd_chunk_count_o),
    .fill_count_o       (fill_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: beats written into the current chunk, slot being written,
  // queue of completed slots awaiting the reader, and the reader's next slot.
  int          m_beat;
  int          m_slot;
  int          m_rd;
  int          m_filled[$];
  bit          m_done;
  int          m_done_slot;
  bit          e_wv;
  bit          e_done;
  int          e_dat;
  int          e_chunk;
  logic [31:0]  e_sm;
  logic [255:0] e_nz;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic model_reset();
    m_beat = 0; m_slot = 0; m_rd = 0; m_done = 0; m_done_slot = 0;
    m_filled.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, src_ready_o, 0);
    chk({tag, "_wv"},    wr_valid_o, 0);
    chk({tag, "_done"},  chunk_done_o, 0);
    chk({tag, "_fill"},  fill_count_o, 0);
    chk({tag, "_avail"}, chunk_avail_o, 0);
    chk({tag, "_rd"},    rd_chunk_count_o, 0);
    chk({tag, "_dat"},   wr_dat_count_o, 0);
    chk({tag, "_chunk"}, wr_chunk_count_o, 0);
    chk({tag, "_sm"},    wr_sparsemap_o, 0);
    chk({tag, "_nz"},    wr_nonzero_data_o, 0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check the handshake,
  // advance the model, then check the registered write after the rising edge.
  task automatic step(input bit v, input bit ab, input bit rel);
    logic [31:0]  sm;
    logic [255:0] nz;
    bit           exp_ready;
    bit           acc;
    sm = $urandom;
    for (int i = 0; i < 8; i++) nz[i*32 +: 32] = $urandom;
    src_valid_i = v; abort_i = ab; chunk_release_i = rel;
    src_sparsemap_i = sm; src_nonzero_data_i = nz;
    #1;
    exp_ready = ((m_filled.size() + (m_done ? 1 : 0)) < SLOTS) && !ab;
    chk("src_ready", src_ready_o, exp_ready);
    chk("fill",      fill_count_o, m_filled.size());
    chk("avail",     chunk_avail_o, m_filled.size() != 0);
    chk("rd_ptr",    rd_chunk_count_o, m_rd);
    acc = v && exp_ready;
    if (rel && m_filled.size() != 0) begin
      void'(m_filled.pop_front());
      m_rd = (m_rd + 1) % SLOTS;
    end
    if (m_done) m_filled.push_back(m_done_slot);
    e_wv   = acc;
    e_done = acc && (m_beat == BEATS - 1);
    if (acc) begin
      e_dat = m_beat; e_chunk = m_slot; e_sm = sm; e_nz = nz;
      m_done_slot = m_slot;
      if (m_beat == BEATS - 1) begin
        m_beat = 0;
        m_slot = (m_slot + 1) % SLOTS;
      end else begin
        m_beat++;
      end
    end
    if (ab) m_beat = 0;
    m_done = e_done;
    @(posedge clk_i);
    #1;
    chk("wr_valid",   wr_valid_o, e_wv);
    chk("chunk_done", chunk_done_o, e_done);
    if (e_wv) begin
      chk("wr_dat_count",   wr_dat_count_o, e_dat);
      chk("wr_chunk_count", wr_chunk_count_o, e_chunk);
      chk("wr_sparsemap",   wr_sparsemap_o, e_sm);
      chk("wr_nonzero",     wr_nonzero_data_o, e_nz);
    end
    @(negedge clk_i);
  endtask

  task automatic async_reset(input string tag);
    src_valid_i = 1'b0; abort_i = 1'b0; chunk_release_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 chk_all_zero(tag);
    @(negedge clk_i);
    @(negedge clk_i);
    chk_all_zero({tag, "_hold"});
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_ni = 1'b0;
    src_valid_i = 1'b0; abort_i = 1'b0; chunk_release_i = 1'b0;
    src_sparsemap_i = '0; src_nonzero_data_i = '0;
    model_reset();
    #3 chk_all_zero("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Release with nothing filled is ignored.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("empty_release_rd", rd_chunk_count_o, 0);

    // One chunk streamed back-to-back into slot 0.
    for (int i = 0; i < BEATS; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("first_chunk_fill", fill_count_o, 1);

    // Two beats, abort, then the chunk restarts at beat 0 in the same slot.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < BEATS; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("after_abort_fill", fill_count_o, 2);

    // Bring occupancy to one, then release in the same cycle a chunk completes.
    step(0, 0, 1);
    for (int i = 0; i < BEATS; i++) step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("coincident_fill", fill_count_o, 1);
    chk("coincident_rd",   rd_chunk_count_o, 2);

    // Reset mid-chunk after two beats of slot 1.
    async_reset("r0");
    for (int i = 0; i < BEATS + 2; i++) step(1, 0, 0);
    async_reset("r1");

    // Fill all slots, hold the next beat, then release one slot.
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("full_fill",  fill_count_o, SLOTS);
    chk("full_ready", src_ready_o, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
